// File: rtl/csr_rd_mux.sv
// Registered CSR read multiplexer: captures one of NUM_CH channels on a strobe, either by
// direct select or by an auto-incrementing scan index, and counts out-of-range selects.
module csr_rd_mux #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     en,
    input  logic                     scan_mode,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        out,
    output logic                     out_valid,
    output logic                     sel_err,
    output logic [SEL_W-1:0]         scan_idx,
    output logic [7:0]               err_cnt
);

    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_CH - 1);

    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [SEL_W-1:0]  scan_idx_q, scan_idx_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_data;
    logic              cap_hit;

    // An index with no matching channel leaves cap_data at zero and cap_hit low.
    always_comb begin
        cap_idx  = scan_mode ? scan_idx_q : sel;
        cap_data = '0;
        cap_hit  = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cap_idx == SEL_W'(k)) begin
                cap_data = ch_data[k*DATA_W +: DATA_W];
                cap_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        out_d      = en ? cap_data : out_q;
        valid_d    = en;
        err_d      = en & ~cap_hit;
        scan_idx_d = scan_idx_q;
        if (!scan_mode) begin
            scan_idx_d = '0;
        end else if (en) begin
            scan_idx_d = (scan_idx_q == LastIdx) ? '0 : scan_idx_q + 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            out_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            scan_idx_q <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            out_q      <= out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            scan_idx_q <= scan_idx_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign scan_idx  = scan_idx_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_csr_rd_mux.sv
// Randomized self-checking bench for csr_rd_mux: an 8-channel and a 6-channel instance share
// control inputs and are compared each cycle against an arithmetic reference model.
module tb_csr_rd_mux;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [63:0] ch_a;
    logic [47:0] ch_b;
    logic [2:0]  sel;
    logic        en, scan_mode, err_clr;

    logic [7:0] out_a, out_b, cnt_a, cnt_b;
    logic       valid_a, valid_b, err_a, err_b;
    logic [2:0] idx_a, idx_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_out[2], m_valid[2], m_err[2], m_pos[2], m_cnt[2];

    always #5 PCLK = ~PCLK;

    assign ch_b = ch_a[47:0];

    csr_rd_mux #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) u_dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn), .ch_data(ch_a), .sel(sel), .en(en),
        .scan_mode(scan_mode), .err_clr(err_clr), .out(out_a), .out_valid(valid_a),
        .sel_err(err_a), .scan_idx(idx_a), .err_cnt(cnt_a)
    );

    csr_rd_mux #(.DATA_W(8), .NUM_CH(6), .SEL_W(3)) u_dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn), .ch_data(ch_b), .sel(sel), .en(en),
        .scan_mode(scan_mode), .err_clr(err_clr), .out(out_b), .out_valid(valid_b),
        .sel_err(err_b), .scan_idx(idx_b), .err_cnt(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 0; m_valid[d] = 0; m_err[d] = 0; m_pos[d] = 0; m_cnt[d] = 0;
        end
    endtask

    // Reference behaviour per instance d (0: 8 channels, 1: 6 channels).
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n, idx;
            n   = (d == 0) ? 8 : 6;
            idx = scan_mode ? m_pos[d] : int'(sel);
            m_valid[d] = en ? 1 : 0;
            m_err[d]   = (en && idx >= n) ? 1 : 0;
            if (en) m_out[d] = (idx < n) ? int'(ch_a[idx*8 +: 8]) : 0;
            if (!scan_mode) m_pos[d] = 0;
            else if (en) m_pos[d] = (m_pos[d] + 1) % n;
            if (err_clr) m_cnt[d] = 0;
            else if (m_err[d] == 1) m_cnt[d] = (m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1;
        end
    endtask

    task automatic compare_all();
        check_eq("a_out", 32'(out_a), m_out[0]);
        check_eq("a_valid", 32'(valid_a), m_valid[0]);
        check_eq("a_err", 32'(err_a), m_err[0]);
        check_eq("a_idx", 32'(idx_a), m_pos[0]);
        check_eq("a_cnt", 32'(cnt_a), m_cnt[0]);
        check_eq("b_out", 32'(out_b), m_out[1]);
        check_eq("b_valid", 32'(valid_b), m_valid[1]);
        check_eq("b_err", 32'(err_b), m_err[1]);
        check_eq("b_idx", 32'(idx_b), m_pos[1]);
        check_eq("b_cnt", 32'(cnt_b), m_cnt[1]);
    endtask

    // Inputs are already driven; advance one edge, update model and compare.
    task automatic step();
        @(posedge PCLK);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic drive(input logic [2:0] s, input logic e, input logic sm, input logic clr);
        sel = s; en = e; scan_mode = sm; err_clr = clr;
    endtask

    task automatic set_default_data();
        for (int k = 0; k < 8; k++) ch_a[k*8 +: 8] = 8'h10 + 8'(k);
    endtask

    initial begin
        PRESETn = 1'b0;
        set_default_data();
        drive(3'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        compare_all();
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;

        // Direct read of channel 5, then hold.
        drive(3'd5, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("direct_out", 32'(out_a), 32'h15);
        check_eq("direct_valid", 32'(valid_a), 32'd1);
        drive(3'd2, 1'b0, 1'b0, 1'b0);
        ch_a[5*8 +: 8] = 8'hEE;
        step();
        check_eq("hold_out", 32'(out_a), 32'h15);
        check_eq("hold_valid", 32'(valid_a), 32'd0);
        set_default_data();

        // Scan with wrap over ten captures.
        drive(3'd7, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("scan_seq", 32'(out_a), 32'h10 + 32'(i % 8));
        end
        check_eq("scan_end_idx", 32'(idx_a), 32'd2);

        // Leaving scan mode: capture uses sel, index returns to zero.
        drive(3'd3, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("scan_exit_out", 32'(out_a), 32'h13);
        check_eq("scan_exit_idx", 32'(idx_a), 32'd0);

        // Out-of-range on the 6-channel instance, then saturation.
        drive(3'd7, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("oor_out", 32'(out_b), 32'd0);
        check_eq("oor_err", 32'(err_b), 32'd1);
        check_eq("oor_cnt", 32'(cnt_b), 32'd1);
        for (int i = 0; i < 300; i++) step();
        check_eq("sat_cnt", 32'(cnt_b), 32'd255);

        // Clear wins over a simultaneous error capture.
        drive(3'd6, 1'b1, 1'b0, 1'b1);
        step();
        check_eq("clr_cnt", 32'(cnt_b), 32'd0);
        check_eq("clr_err", 32'(err_b), 32'd1);

        // Asynchronous reset between edges during a scan.
        drive(3'd0, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        #3;
        PRESETn = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        PRESETn = 1'b1;
        step();
        check_eq("post_rst_out", 32'(out_a), 32'h10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ch_a = {$urandom, $urandom};
            sel  = 3'($urandom_range(0, 7));
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) scan_mode = ~scan_mode;
            err_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_rd_mux.md
CSR_RD_MUX -- requirements
Module: csr_rd_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the channel data width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 8, giving the number of input channels (2..256).
REQ-003 The block SHALL have parameter SEL_W, default 3, giving the select width; SEL_W >= clog2(NUM_CH).
REQ-004 The block SHALL have port PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port ch_data, input, NUM_CH*DATA_W bits: flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index in direct mode.
REQ-008 The block SHALL have port en, input, 1 bit: capture strobe.
REQ-009 The block SHALL have port scan_mode, input, 1 bit: 0 = direct select, 1 = auto-increment scan.
REQ-010 The block SHALL have port err_clr, input, 1 bit: synchronous clear of the error counter.
REQ-011 The block SHALL have port out, output, DATA_W bits: registered selected data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new out value.
REQ-013 The block SHALL have port sel_err, output, 1 bit: one-cycle pulse marking an out-of-range capture.
REQ-014 The block SHALL have port scan_idx, output, SEL_W bits: current internal scan index.
REQ-015 The block SHALL have port err_cnt, output, 8 bits: saturating count of out-of-range captures.

Function
REQ-016 The block SHALL capture on each rising edge where en=1, with the captured index being sel if scan_mode=0 and scan_idx if scan_mode=1.
REQ-017 On a capture, out SHALL take the selected channel's data on that same edge (1-cycle latency from en), and out_valid SHALL be 1 for the following cycle.
REQ-018 On a cycle with en=0, out SHALL hold its previous value, and out_valid and sel_err SHALL be 0.
REQ-019 On a capture with index >= NUM_CH, out SHALL load all zeros, out_valid SHALL be 1 and sel_err SHALL be 1 for that cycle.
REQ-020 While scan_mode=0, scan_idx SHALL be held at 0.
REQ-021 While scan_mode=1, each capture SHALL use the current scan_idx and then advance scan_idx by 1, wrapping from NUM_CH-1 to 0.
REQ-022 In scan mode, scan_idx SHALL never reach NUM_CH or above, so sel_err SHALL never be asserted.
REQ-023 When scan_mode and en first rise on the same edge, the capture SHALL use index 0, and scan_idx SHALL become 1 (0 if NUM_CH=1 is excluded by REQ-002).
REQ-024 When scan_mode falls, scan_idx SHALL be 0 on the next edge, and any capture on that edge SHALL use sel.
REQ-025 err_cnt SHALL increment by 1 on each sel_err capture and saturate at 255.
REQ-026 When err_clr=1, err_cnt SHALL become 0, taking precedence over a simultaneous increment.
REQ-027 ch_data SHALL be sampled only on capture edges; changes at any other time SHALL not affect out.

Reset
REQ-028 PRESETn=0 SHALL immediately, without a clock edge, force out=0, out_valid=0, sel_err=0, scan_idx=0 and err_cnt=0.
REQ-029 Reset asserted mid-scan SHALL restart scanning from index 0 after PRESETn is released.
REQ-030 The first capture after reset release SHALL occur on the first rising edge with PRESETn=1 and en=1.

Verification (defaults, ch k = 8'h10+k)
REQ-031 Direct read: with sel=5 and en=1 for one cycle, the next cycle SHALL show out=8'h15 and out_valid=1, then out SHALL hold 8'h15 with out_valid=0.
REQ-032 Scan wrap: with scan_mode=1 and en=1 for 10 cycles, out SHALL follow the sequence 10,11,...,17,10,11, and scan_idx SHALL end at 2.
REQ-033 Out-of-range read: with NUM_CH=6 and sel=7 with en=1, the bench SHALL see out=0, sel_err=1 and err_cnt=1; 300 such captures SHALL give err_cnt=255.
REQ-034 Clear precedence: with err_clr=1 and an error capture on the same cycle, err_cnt SHALL be 0.
REQ-035 Async reset: PRESETn pulsed low between edges during a scan SHALL zero all outputs at once, and the next capture SHALL give out=8'h10.
